// File: rtl/adpcm_main_prod_acc_if.sv
// adpcm_main_prod_acc_if
//   Bundles the product-beat input handshake and the result output handshake
//   of the ADPCM product accumulator.
//   Handshake rule (both directions): a transfer happens on a rising clock
//   edge where valid & ready & ce are all high. The producer holds valid and
//   its payload steady until that edge. ready never depends on valid.
//   Modports:
//     slave  : accumulator side (consumes beats, produces results)
//     master : environment side (produces beats, consumes results)
//   Signals:
//     in_valid/in_data/in_last/in_ready : signed product beats
//     out_valid/out_data/out_overrun/out_ready : shifted, saturated result
interface adpcm_main_prod_acc_if #(
    parameter int DIN_WIDTH  = 45,
    parameter int DOUT_WIDTH = 32
);
    logic                  in_valid;
    logic [DIN_WIDTH-1:0]  in_data;
    logic                  in_last;
    logic                  in_ready;
    logic                  out_valid;
    logic [DOUT_WIDTH-1:0] out_data;
    logic                  out_overrun;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_overrun
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_overrun
    );
endinterface

// File: rtl/adpcm_main_prod_acc.sv
// adpcm_main_prod_acc
//   Sums a burst of signed products in a widened accumulator, applies the
//   arithmetic right shift of the ADPCM filter equations and presents a
//   DOUT_WIDTH-bit result. A burst ends on in_last or is force-terminated
//   after MAX_TAPS beats (flagged by out_overrun).
//   Optional feature: define ADPCM_PROD_ACC_SAT_EN to clamp the shifted sum
//   to the signed DOUT_WIDTH range; otherwise the result wraps.
//   Ports:
//     clk       : rising-edge clock
//     reset     : synchronous active-high reset, wins over ce
//     ce        : clock enable; 0 freezes all state and blocks both handshakes
//     bus       : adpcm_main_prod_acc_if.slave (beat input, result output)
//     state_dbg : current FSM state (0 IDLE, 1 ACC, 2 HOLD)
module adpcm_main_prod_acc #(
    parameter int DIN_WIDTH  = 45,
    parameter int ACC_WIDTH  = 48,
    parameter int DOUT_WIDTH = 32,
    parameter int SHIFT      = 14,
    parameter int MAX_TAPS   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ce,
    adpcm_main_prod_acc_if.slave      bus,
    output logic [1:0]                state_dbg
);
    localparam int CNT_W = $clog2(MAX_TAPS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                       state, state_nxt;
    logic signed [ACC_WIDTH-1:0]  acc;
    logic signed [ACC_WIDTH-1:0]  din_ext;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic [CNT_W-1:0]             count, count_nxt;
    logic [DOUT_WIDTH-1:0]        res;
    logic [DOUT_WIDTH-1:0]        out_data_q;
    logic                         out_overrun_q;
    logic                         in_ready;
    logic                         accept;
    logic                         at_limit;
    logic                         burst_end;
    logic                         out_fire;

    assign in_ready  = ce & (state != S_HOLD);
    assign accept    = bus.in_valid & in_ready;
    assign din_ext   = {{(ACC_WIDTH-DIN_WIDTH){bus.in_data[DIN_WIDTH-1]}}, bus.in_data};

    // The first beat of a burst starts from zero, so the sum never depends
    // on whatever acc held while idle.
    assign sum       = ((state == S_ACC) ? acc : '0) + din_ext;
    assign count_nxt = ((state == S_ACC) ? count : '0) + CNT_W'(1);
    assign at_limit  = (count_nxt == CNT_W'(MAX_TAPS));
    assign burst_end = accept & (bus.in_last | at_limit);
    assign out_fire  = ce & (state == S_HOLD) & bus.out_ready;

    // Arithmetic shift: floors toward minus infinity, no rounding.
    assign shifted   = sum >>> SHIFT;

`ifdef ADPCM_PROD_ACC_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

    always_comb begin
        res = DOUT_WIDTH'(shifted);
        if (shifted > SAT_MAX) begin
            res = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            res = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
        end
    end
`else
    assign res = DOUT_WIDTH'(shifted);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ACC: begin
                if (burst_end) begin
                    state_nxt = S_HOLD;
                end else if (accept) begin
                    state_nxt = S_ACC;
                end
            end
            S_HOLD: begin
                if (out_fire) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            acc           <= '0;
            count         <= '0;
            out_data_q    <= '0;
            out_overrun_q <= 1'b0;
        end else if (ce) begin
            state <= state_nxt;
            if (accept) begin
                acc   <= sum;
                count <= count_nxt;
            end
            if (burst_end) begin
                out_data_q    <= res;
                // A beat that carries in_last at the limit is a normal end.
                out_overrun_q <= ~bus.in_last;
            end
            if (out_fire) begin
                acc   <= '0;
                count <= '0;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = (state == S_HOLD);
    assign bus.out_data    = out_data_q;
    assign bus.out_overrun = out_overrun_q;
    assign state_dbg       = state;
endmodule

// File: tb/tb_adpcm_main_prod_acc.sv
module tb_adpcm_main_prod_acc;
    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    logic       ce;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    adpcm_main_prod_acc_if #(.DIN_WIDTH(45), .DOUT_WIDTH(32)) bus ();

    adpcm_main_prod_acc dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Result of a completed burst sum, straight from the arithmetic rules.
    function automatic logic [31:0] result_of(input longint s);
        longint sh;
        sh = s >>> 14;
`ifdef ADPCM_PROD_ACC_SAT_EN
        if (sh > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sh < -64'sd2147483648) return 32'h8000_0000;
`endif
        return sh[31:0];
    endfunction

    // Scoreboard: results produced but not yet taken by the environment.
    logic [31:0] exp_q[$];
    logic        ovr_q[$];
    longint      m_sum = 0;
    int          m_cnt = 0;
    bit          model_on = 1'b0;

    // Compare current outputs, then advance the model with the inputs that
    // the coming rising edge will see (inputs change only just after posedge).
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_in_ready", bus.in_ready, (ce && exp_q.size() == 0));
            chk("m_out_valid", bus.out_valid, (exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("m_out_data", bus.out_data, exp_q[0]);
                chk("m_out_overrun", bus.out_overrun, ovr_q[0]);
            end
        end
        if (reset) begin
            m_sum = 0;
            m_cnt = 0;
            exp_q.delete();
            ovr_q.delete();
            model_on = 1'b1;
        end else if (ce) begin
            if (exp_q.size() != 0) begin
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    void'(ovr_q.pop_front());
                end
            end else if (bus.in_valid) begin
                m_sum += longint'($signed(bus.in_data));
                m_cnt++;
                if (bus.in_last || m_cnt == 8) begin
                    exp_q.push_back(result_of(m_sum));
                    ovr_q.push_back(!bus.in_last);
                    m_sum = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_beat(input longint d, input bit last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d[44:0];
        bus.in_last  = last;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic take_result(input string name, input logic [31:0] ed, input bit eo,
                               output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.out_valid && ce) begin
                ok = 1'b1;
                break;
            end
            waited++;
        end
        chk({name, "_seen"}, 64'(ok), 64'd1);
        chk({name, "_data"}, 64'(bus.out_data), 64'(ed));
        chk({name, "_ovr"}, 64'(bus.out_overrun), 64'(eo));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    longint big_pos;
    longint big_neg;
    int     w;

    initial begin
        big_pos = (longint'(1) <<< 44) - 1;
        big_neg = -(longint'(1) <<< 44);
        reset = 1'b1;
        ce    = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        idle_cycles(2);
        reset = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_overrun", 64'(bus.out_overrun), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        idle_cycles(1);

        // 16384 + 16384 = 32768 -> >>>14 = 2, result one cycle after accept
        send_beat(16384, 1'b0);
        send_beat(16384, 1'b1);
        take_result("two_beats", 32'd2, 1'b0, w);
        chk("two_beats_latency", 64'(w), 64'd0);

        // -1 >>> 14 = -1
        send_beat(-1, 1'b1);
        take_result("minus_one", 32'hFFFF_FFFF, 1'b0, w);

        // 4*(2^44-1) >>> 14 = 2^32-1
        for (int i = 0; i < 4; i++) send_beat(big_pos, (i == 3));
`ifdef ADPCM_PROD_ACC_SAT_EN
        take_result("max_pos", 32'h7FFF_FFFF, 1'b0, w);
`else
        take_result("max_pos", 32'hFFFF_FFFF, 1'b0, w);
`endif

        // 4*(-2^44) >>> 14 = -2^32
        for (int i = 0; i < 4; i++) send_beat(big_neg, (i == 3));
`ifdef ADPCM_PROD_ACC_SAT_EN
        take_result("max_neg", 32'h8000_0000, 1'b0, w);
`else
        take_result("max_neg", 32'h0000_0000, 1'b0, w);
`endif

        // eight beats without in_last: forced end, overrun flagged
        for (int i = 0; i < 8; i++) send_beat(16384, 1'b0);
        @(negedge clk);
        chk("overrun_in_ready", 64'(bus.in_ready), 64'd0);
        idle_cycles(1);
        take_result("overrun", 32'd8, 1'b1, w);

        // in_last on beat eight: normal end
        for (int i = 0; i < 8; i++) send_beat(16384, (i == 7));
        take_result("last_at_max", 32'd8, 1'b0, w);

        // gaps inside a burst: 100000 - 300000 + 7 = -199993 -> floor(/16384) = -13
        send_beat(100000, 1'b0);
        idle_cycles(3);
        send_beat(-300000, 1'b0);
        idle_cycles(2);
        send_beat(7, 1'b1);
        take_result("gaps", 32'hFFFF_FFF3, 1'b0, w);

        // held result, then ce=0 blocks the output handshake
        send_beat(81920, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_data", 64'(bus.out_data), 64'd5);
        end
        idle_cycles(1);
        bus.out_ready = 1'b1;
        ce = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("ce_off_valid", 64'(bus.out_valid), 64'd1);
            chk("ce_off_data", 64'(bus.out_data), 64'd5);
            chk("ce_off_in_ready", 64'(bus.in_ready), 64'd0);
        end
        idle_cycles(1);
        ce = 1'b1;
        take_result("ce_resume", 32'd5, 1'b0, w);
        chk("ce_resume_wait", 64'(w), 64'd0);
        @(negedge clk);
        chk("ce_resume_done", 64'(bus.out_valid), 64'd0);
        idle_cycles(1);

        // reset in the middle of a burst discards the partial sum
        for (int i = 0; i < 3; i++) send_beat(16384, 1'b0);
        reset = 1'b1;
        idle_cycles(1);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_out_data", 64'(bus.out_data), 64'd0);
        idle_cycles(1);
        send_beat(16384, 1'b1);
        take_result("after_reset", 32'd1, 1'b0, w);

        idle_cycles(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
